// File: rtl/writeback_arbiter_if.sv
// Write-back handshake bundle: pipeline producer, long-latency producer and
// register file write port. The producers/bench use master; the arbiter uses slave.
interface writeback_arbiter_if;
  logic        pValid;
  logic        pReady;
  logic [4:0]  pDest;
  logic        pRegWrite;
  logic        pMemToReg;
  logic [2:0]  pLoadType;
  logic [1:0]  pAddrLow;
  logic [31:0] pAluResult;
  logic [31:0] pMemData;
  logic        lValid;
  logic        lReady;
  logic [4:0]  lDest;
  logic [31:0] lData;
  logic [4:0]  writeRegister;
  logic [31:0] writeData;
  logic        regWrite;

  modport master (
    output pValid, pDest, pRegWrite, pMemToReg, pLoadType, pAddrLow,
           pAluResult, pMemData, lValid, lDest, lData,
    input  pReady, lReady, writeRegister, writeData, regWrite
  );

  modport slave (
    input  pValid, pDest, pRegWrite, pMemToReg, pLoadType, pAddrLow,
           pAluResult, pMemData, lValid, lDest, lData,
    output pReady, lReady, writeRegister, writeData, regWrite
  );
endinterface

// File: rtl/writeback_arbiter.sv
// Write-back arbiter: picks between the main pipeline and the long-latency
// unit, aligns/extends load data, blocks writes to r0 and registers the
// register file write port. The pipeline has priority until the long-latency
// producer has lost MAX_WAIT arbitrations in a row, then it is forced through.
// Optional: define WB_PERF_EN to add commitCount/stallCount outputs.
module writeback_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int WAIT_W   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  writeback_arbiter_if.slave    wb
`ifdef WB_PERF_EN
  ,
  output logic [31:0]           commitCount,
  output logic [31:0]           stallCount
`endif
);

  localparam logic [WAIT_W-1:0] MAX_CNT = WAIT_W'(MAX_WAIT);

  typedef enum logic [2:0] {
    LD_W  = 3'b000,
    LD_B  = 3'b001,
    LD_BU = 3'b010,
    LD_H  = 3'b011,
    LD_HU = 3'b100
  } load_t;

  logic [WAIT_W-1:0] waitCnt;
  logic              forced;
  logic              pAccept;
  logic              lAccept;
  logic [7:0]        loadByte;
  logic [15:0]       loadHalf;
  logic [31:0]       loadValue;
  logic [31:0]       pData;

  // Ready generation; both readies are held low while reset is asserted.
  always_comb begin
    forced    = (waitCnt == MAX_CNT) && wb.lValid;
    wb.pReady = rst_n && !forced;
    wb.lReady = rst_n && wb.lValid && (forced || !wb.pValid);
    pAccept   = wb.pValid && wb.pReady;
    lAccept   = wb.lValid && wb.lReady;
  end

  // Little-endian load alignment and sign/zero extension.
  always_comb begin
    loadByte  = 8'h00;
    loadHalf  = wb.pAddrLow[1] ? wb.pMemData[31:16] : wb.pMemData[15:0];
    loadValue = wb.pMemData;
    case (wb.pAddrLow)
      2'd0:    loadByte = wb.pMemData[7:0];
      2'd1:    loadByte = wb.pMemData[15:8];
      2'd2:    loadByte = wb.pMemData[23:16];
      default: loadByte = wb.pMemData[31:24];
    endcase
    case (load_t'(wb.pLoadType))
      LD_B:    loadValue = {{24{loadByte[7]}}, loadByte};
      LD_BU:   loadValue = {24'h000000, loadByte};
      LD_H:    loadValue = {{16{loadHalf[15]}}, loadHalf};
      LD_HU:   loadValue = {16'h0000, loadHalf};
      default: loadValue = wb.pMemData;
    endcase
    pData = wb.pMemToReg ? loadValue : wb.pAluResult;
  end

  // Starvation counter: counts consecutive lost arbitrations, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waitCnt <= '0;
    end else if (!wb.lValid || lAccept) begin
      waitCnt <= '0;
    end else if (waitCnt != MAX_CNT) begin
      waitCnt <= waitCnt + 1'b1;
    end
  end

  // Registered register-file write port; address/data hold between accepts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb.writeRegister <= 5'd0;
      wb.writeData     <= 32'd0;
      wb.regWrite      <= 1'b0;
    end else if (pAccept) begin
      wb.writeRegister <= wb.pDest;
      wb.writeData     <= pData;
      wb.regWrite      <= wb.pRegWrite && (wb.pDest != 5'd0);
    end else if (lAccept) begin
      wb.writeRegister <= wb.lDest;
      wb.writeData     <= wb.lData;
      wb.regWrite      <= (wb.lDest != 5'd0);
    end else begin
      wb.regWrite      <= 1'b0;
    end
  end

`ifdef WB_PERF_EN
  logic commitNext;
  logic stallNow;

  // Performance event decode for the counters below.
  always_comb begin
    commitNext = (pAccept && wb.pRegWrite && (wb.pDest != 5'd0)) ||
                 (lAccept && (wb.lDest != 5'd0));
    stallNow   = (wb.lValid && !wb.lReady) || (wb.pValid && !wb.pReady);
  end

  // Free-running, wrapping commit and stall counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      commitCount <= 32'd0;
      stallCount  <= 32'd0;
    end else begin
      if (commitNext) commitCount <= commitCount + 32'd1;
      if (stallNow)   stallCount  <= stallCount + 32'd1;
    end
  end
`endif

endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
Write-back stage directly upstream of the register file write port (writeRegister/writeData/regWrite). Arbitrates between two producers: the main pipeline (MEM results: ALU result or load data) and a long-latency unit (mul/div). Performs load byte/halfword extraction and sign extension, and suppresses writes to register 0. All outputs are registered, so the register file samples stable values on its posedge write.

Parameters:
MAX_WAIT, 4, consecutive cycles the long-latency producer may lose arbitration before it is forced to win one cycle (range 1-15)
WAIT_W, 4, width of the starvation counter; must hold MAX_WAIT

Ports:
clk  in  1  clock, all state updates on posedge
rst_n  in  1  asynchronous active-low reset
pValid  in  1  pipeline result valid
pReady  out  1  pipeline result accepted this cycle
pDest  in  5  pipeline destination register
pRegWrite  in  1  pipeline op writes a register
pMemToReg  in  1  1 = select load data, 0 = ALU result
pLoadType  in  3  000 lw, 001 lb, 010 lbu, 011 lh, 100 lhu, others treated as lw
pAddrLow  in  2  low address bits of the load
pAluResult  in  32  ALU result
pMemData  in  32  raw 32-bit memory word
lValid  in  1  long-latency result valid
lReady  out  1  long-latency result accepted this cycle
lDest  in  5  long-latency destination register
lData  in  32  long-latency result
writeRegister  out  5  register file write address
writeData  out  32  register file write data
regWrite  out  1  register file write enable

Behaviour:
- Reset (async, rst_n low): writeRegister=0, writeData=0, regWrite=0, starvation counter=0. pReady and lReady are forced 0 while rst_n is low.
- Transfer rule: a producer's op is accepted at the posedge where its valid and ready are both high.
- Readies are combinational from valids and the counter. Default: pReady=1 and lReady = lValid & ~pValid.
- Forced mode applies when counter==MAX_WAIT and lValid=1. Then lReady=1 and pReady=0.
- Starvation counter:
  - Increments on each posedge where lValid=1 and the long-latency op is not accepted.
  - Resets to 0 on long-latency acceptance or when lValid=0.
  - Saturates at MAX_WAIT.
- Data select, pipeline:
  - pMemToReg=0 gives pAluResult.
  - pMemToReg=1 gives the load-aligned value, little-endian:
    - lb/lbu: byte = pMemData[8*pAddrLow +: 8], sign- or zero-extended.
    - lh/lhu: half = pMemData[16*pAddrLow[1] +: 16], sign- or zero-extended; pAddrLow[0] ignored.
    - lw: pAddrLow ignored.
- Data select, long-latency: lData.
- Latency: an op accepted at edge N drives writeRegister/writeData/regWrite from edge N until edge N+1. The register file commits at edge N+1.
- regWrite after edge N:
  - 1 iff an op was accepted at N, it requests a write (pRegWrite for the pipeline; always for the long-latency unit), and the destination is not 0.
  - Otherwise 0.
- writeRegister/writeData update only on acceptance and hold their last value otherwise.
- At most one op is accepted per cycle. Both valid, not forced: the pipeline wins and the long-latency op waits.
- Accepted pipeline op with pRegWrite=0: regWrite=0 that cycle, but the op still counts as accepted.
- Reset mid-operation: all outputs return to their reset values immediately. A pending long-latency op is not accepted; the producer must hold it valid after reset releases.

Optional Feature:
WB_PERF_EN:
- Defined: adds outputs commitCount[31:0] and stallCount[31:0], both reset to 0 and wrapping at 2^32.
  - commitCount increments on every edge where regWrite is driven 1 for the following cycle.
  - stallCount increments on every edge where lValid=1 and lReady=0, or pValid=1 and pReady=0.
- Undefined: both ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Pipeline ALU op: pValid=1, pDest=5, pRegWrite=1, pMemToReg=0, pAluResult=0x12345678 -> next cycle regWrite=1, writeRegister=5, writeData=0x12345678, then regWrite=0.
- Loads with pMemData=0x80FF7F01 -> expected writeData:
  - lb, addrLow=3: 0xFFFFFF80.
  - lbu, addrLow=1: 0x0000007F.
  - lh, addrLow=2: 0xFFFF80FF.
  - lhu, addrLow=3: 0x000080FF.
  - lw: 0x80FF7F01.
- Write to r0: pDest=0, pRegWrite=1 -> pReady=1, regWrite stays 0.
- Contention with MAX_WAIT=4: pValid and lValid held high -> pipeline accepted 4 cycles, 5th cycle pReady=0 and lReady=1, lData committed; counter back to 0 and pipeline resumes.
- Long-latency alone: lValid=1, lDest=31, lData=0xDEADBEEF with pValid=0 -> same-cycle lReady=1; next cycle writeRegister=31, writeData=0xDEADBEEF, regWrite=1.
- Async reset: assert rst_n low mid-cycle while regWrite=1 -> regWrite, writeRegister and writeData drop to 0 without waiting for a clock edge; readies 0 until release.
